// File: rtl/vga_dbuf_ctrl_pkg.sv
// Shared definitions for the double-buffered VGA framebuffer controller:
// FSM encoding, default resolution and bank sizing helper.
package vga_dbuf_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SWAP_PEND = 2'd1,
        CLEAR     = 2'd2
    } state_t;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_SCALE_LOG2 = 2;

    function automatic int bank_depth(input int h, input int v, input int s);
        return (h >> s) * (v >> s);
    endfunction

endpackage

// File: rtl/vga_dbuf_ctrl_if.sv
// Back-buffer write port: valid/ready handshake plus the dropped-write flag.
interface vga_dbuf_ctrl_if #(
    parameter int ADDR_W = 15,
    parameter int PIX_W  = 24
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_err;

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready, wr_err
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready, wr_err
    );
endinterface

// File: rtl/vga_dbuf_ctrl_fb_bank_ram.sv
// One framebuffer bank: single-port synchronous RAM, registered read output.
module fb_bank_ram #(
    parameter int DEPTH  = 19200,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 24
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wren) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

endmodule

// File: rtl/vga_dbuf_ctrl.sv
// Double-buffered VGA framebuffer: display reads the front bank, host writes
// the back bank, banks swap on a frame_done edge with an optional back clear.
module vga_dbuf_ctrl
    import vga_dbuf_ctrl_pkg::*;
#(
    parameter int                H_ACTIVE    = DEF_H_ACTIVE,
    parameter int                V_ACTIVE    = DEF_V_ACTIVE,
    parameter int                SCALE_LOG2  = DEF_SCALE_LOG2,
    parameter int                PIX_W       = 24,
    parameter logic [PIX_W-1:0]  CLEAR_COLOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             active_pixels,
    input  logic             frame_done,
    vga_dbuf_ctrl_if.slave   wr,
    input  logic             clear_en,
    input  logic             swap_req,
    output logic             swap_ack,
    output logic             front_id,
    output logic [PIX_W-1:0] pix_out,
    output logic             pix_valid
);

    localparam int VW     = H_ACTIVE >> SCALE_LOG2;
    localparam int DEPTH  = bank_depth(H_ACTIVE, V_ACTIVE, SCALE_LOG2);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int AW1    = ADDR_W + 1;

    state_t            state, state_nx;
    logic              front_nx;
    logic              ack_nx;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
    logic              pend, pend_nx;
    logic              fd_prev;
    logic              fd_rise;
    logic              ready_en;
    logic              wr_err_q;

    logic [AW1-1:0]    rd_raw;
    logic [ADDR_W-1:0] rd_addr_p0;
    logic              vld_p0;
    logic              vld_p1;
    logic              sel_p1;

    logic              wr_hs;
    logic              addr_ok;
    logic              host_we;
    logic              clr_we;
    logic              back_we;
    logic [ADDR_W-1:0] back_addr;
    logic [PIX_W-1:0]  back_data;

    logic [ADDR_W-1:0] bank_addr [2];
    logic              bank_we   [2];
    logic [PIX_W-1:0]  bank_q    [2];

    // Read address: full-width arithmetic, out-of-range positions fold to 0
    always_comb begin
        rd_raw = AW1'(y >> SCALE_LOG2) * AW1'(VW) + AW1'(x >> SCALE_LOG2);
    end

    // Stage p0: registered read address and valid
    always_ff @(posedge clk) begin
        rd_addr_p0 <= (rd_raw < AW1'(DEPTH)) ? rd_raw[ADDR_W-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            sel_p1 <= 1'b0;
        end else begin
            vld_p0 <= active_pixels;
            // Stage p1: RAM output; bank select captured with the read
            vld_p1 <= vld_p0;
            sel_p1 <= front_id;
        end
    end

    assign pix_valid = vld_p1;
    assign pix_out   = vld_p1 ? (sel_p1 ? bank_q[1] : bank_q[0]) : '0;

    assign wr.wr_ready = ready_en & (state != CLEAR);
    assign wr.wr_err   = wr_err_q;

    always_comb begin
        wr_hs     = wr.wr_valid & wr.wr_ready;
        addr_ok   = AW1'(wr.wr_addr) < AW1'(DEPTH);
        host_we   = wr_hs & addr_ok;
        clr_we    = (state == CLEAR);
        back_we   = host_we | clr_we;
        back_addr = clr_we ? clr_cnt : ADDR_W'(wr.wr_addr);
        back_data = clr_we ? CLEAR_COLOR : PIX_W'(wr.wr_data);
    end

    // The display always owns the front bank; everything else hits the back
    always_comb begin
        bank_addr[0] = front_id ? back_addr  : rd_addr_p0;
        bank_addr[1] = front_id ? rd_addr_p0 : back_addr;
        bank_we[0]   = front_id  & back_we;
        bank_we[1]   = ~front_id & back_we;
    end

    fb_bank_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (PIX_W)
    ) u_bank0 (
        .clock   (clk),
        .address (bank_addr[0]),
        .data    (back_data),
        .wren    (bank_we[0]),
        .q       (bank_q[0])
    );

    fb_bank_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (PIX_W)
    ) u_bank1 (
        .clock   (clk),
        .address (bank_addr[1]),
        .data    (back_data),
        .wren    (bank_we[1]),
        .q       (bank_q[1])
    );

    assign fd_rise = frame_done & ~fd_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            front_id <= 1'b0;
            swap_ack <= 1'b0;
            clr_cnt  <= '0;
            pend     <= 1'b0;
            fd_prev  <= 1'b0;
            ready_en <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state    <= state_nx;
            front_id <= front_nx;
            swap_ack <= ack_nx;
            clr_cnt  <= clr_cnt_nx;
            pend     <= pend_nx;
            fd_prev  <= frame_done;
            ready_en <= 1'b1;
            wr_err_q <= wr_hs & ~addr_ok;
        end
    end

    always_comb begin
        state_nx   = state;
        front_nx   = front_id;
        ack_nx     = 1'b0;
        clr_cnt_nx = clr_cnt;
        pend_nx    = pend;
        case (state)
            RUN: begin
                if (swap_req) begin
                    state_nx = SWAP_PEND;
                end
            end
            SWAP_PEND: begin
                if (fd_rise) begin
                    front_nx   = ~front_id;
                    ack_nx     = 1'b1;
                    clr_cnt_nx = '0;
                    state_nx   = clear_en ? CLEAR : RUN;
                end
            end
            CLEAR: begin
                if (swap_req) begin
                    pend_nx = 1'b1;
                end
                if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    clr_cnt_nx = '0;
                    state_nx   = pend_nx ? SWAP_PEND : RUN;
                    pend_nx    = 1'b0;
                end else begin
                    clr_cnt_nx = clr_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

endmodule

// File: doc/vga_dbuf_ctrl.md
VGA_DBUF_CTRL -- requirements
Module: vga_dbuf_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible width in screen pixels.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible height in screen pixels.
REQ-003 SHALL have parameter SCALE_LOG2, default 2, virtual pixel size of 2^SCALE_LOG2 screen pixels; VW = H_ACTIVE>>SCALE_LOG2, VH = V_ACTIVE>>SCALE_LOG2.
REQ-004 SHALL have parameter PIX_W, default 24, pixel width in bits.
REQ-005 SHALL have parameter CLEAR_COLOR, default 0, PIX_W-bit fill value.
REQ-006 SHALL have a derived local ADDR_W = clog2(VW*VH), which is 15 at the defaults.
REQ-007 SHALL have ports: clk in 1, system clock; rst in 1, reset. The block uses one clock; reset is asynchronous and active-low.
REQ-008 SHALL have ports: x in 10, y in 10, active_pixels in 1, frame_done in 1. All four come from the VGA timing driver.
REQ-009 SHALL have ports: wr_valid in 1, wr_ready out 1, wr_addr in ADDR_W, wr_data in PIX_W. This is the back-buffer write port.
REQ-010 SHALL have ports: clear_en in 1, swap_req in 1, swap_ack out 1, front_id out 1, wr_err out 1.
REQ-011 SHALL have ports: pix_out out PIX_W, pix_valid out 1.

Function
REQ-012 SHALL hold two banks of VW*VH words. The front bank (index front_id) is read-only to the display. The back bank (the other index) is written only.
REQ-013 SHALL address both banks row-major: addr = (row)*VW + (col).
REQ-014 SHALL form the read address as (y>>SCALE_LOG2)*VW + (x>>SCALE_LOG2) and register it. Arithmetic is ADDR_W+1 bits with no truncation before compare.
REQ-015 SHALL have a read latency of exactly 2 clk from x/y/active_pixels to pix_out/pix_valid: one cycle for the address register and one for the RAM output.
REQ-016 SHALL drive pix_valid as active_pixels delayed 2 cycles. When pix_valid=0, pix_out SHALL be 0.
REQ-017 SHALL accept a write on a cycle with wr_valid & wr_ready. The write lands in the back bank the same edge.
REQ-018 SHALL drop a handshaken write with wr_addr >= VW*VH and pulse wr_err high for 1 cycle on that write.
REQ-019 SHALL use three FSM states: RUN, SWAP_PEND, CLEAR. The reset state is RUN.
REQ-020 RUN: swap_req=1 SHALL go to SWAP_PEND. wr_ready=1.
REQ-021 SWAP_PEND: wr_ready=1. The FSM SHALL detect a rising edge of frame_done (0 in the previous cycle, 1 now). On that edge it SHALL:
  - toggle front_id;
  - pulse swap_ack for 1 cycle;
  - go to CLEAR if clear_en=1, otherwise go to RUN.
REQ-022 SHALL ignore further swap_req pulses while in SWAP_PEND. At most one swap SHALL occur per frame_done edge.
REQ-023 CLEAR: wr_ready=0. A counter from 0 to VW*VH-1 SHALL write CLEAR_COLOR into the new back bank, one word per cycle. After the last address it SHALL return to RUN, so the state lasts exactly VW*VH cycles.
REQ-024 SHALL latch swap_req=1 received during CLEAR into a pending flag. After CLEAR it SHALL enter SWAP_PEND instead of RUN.
REQ-025 SHALL keep reads of the front bank running without interruption through SWAP_PEND and CLEAR.
REQ-026 SHALL not change the front bank mid-frame. A swap takes effect only at a frame_done edge.

Reset
REQ-027 When rst=0, the block SHALL go to:
  - state RUN, front_id=0, swap_ack=0, wr_err=0, wr_ready=0;
  - pix_out=0, pix_valid=0;
  - the clear counter and pending flag at 0.
REQ-028 SHALL drive wr_ready=1 from the first clk edge after rst deasserts.
REQ-029 SHALL not reset RAM contents. A reset during CLEAR SHALL abandon the clear.

Structure
REQ-030 SHALL define the FSM state encodings and the default-resolution constants in a shared package. The default-resolution constants are H_ACTIVE/V_ACTIVE 640/480 and SCALE_LOG2 2.
REQ-031 SHALL implement each bank as one sub-module, fb_bank_ram. It is a single-port synchronous RAM (address, clock, data, wren, q) with 1-cycle read latency, instanced twice.
REQ-032 SHALL steer bank ports combinationally from front_id. This covers the read address, write address, data and wren.

Verification
REQ-033 Reset, then x=4, y=4, active_pixels=1 with bank0 word 161 = 24'h123456 -> after 2 clk, pix_out=24'h123456 and pix_valid=1.
REQ-034 Write 24'hABCDEF to addr 0 in RUN, then swap_req, then a frame_done 0->1 edge:
  - swap_ack pulses once and front_id becomes 1;
  - a subsequent read at x=0, y=0 returns 24'hABCDEF.
REQ-035 clear_en=1 with swap at a frame_done edge:
  - wr_ready=0 for exactly 19200 cycles;
  - afterwards every back-bank word equals CLEAR_COLOR.
REQ-036 wr_addr=19200 with wr_valid=1 in RUN -> wr_err=1 for one cycle, and no bank word changes.
REQ-037 swap_req during CLEAR -> no swap until CLEAR ends. The next frame_done edge swaps back to front_id=0 with a single swap_ack.
REQ-038 Assert rst=0 mid-CLEAR -> all outputs hold their reset values. One cycle after release, wr_ready=1 and front_id=0.
